hart_program_loader: RTL
========================

// Module: hart_program_loader
// PURPOSE
//   Board-side writer into the hart's memory: the counterpart of the LED readout, which reads RAM.
//   Operator sets a byte on switches and presses a key; the block writes it to the next RAM address.
//   Holds the hart in reset while loading and releases it on return to run mode.
//   Sits beside `hart` in the board top and drives the RAM write port plus the hart's reset.
// PARAMETERS
//   ADDR_WIDTH       8        RAM byte-address width (256 B)
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles to accept a key level (10 ms @ 50 MHz)
//   START_ADDR       0        first address written after entering load mode
// PORTS
//   clk           in   1           system clock (CLOCK_50)
//   reset_n       in   1           asynchronous, active-low reset (KEY[0])
//   load_mode     in   1           raw switch; 1 = load, 0 = run
//   byte_in       in   8           raw switches, byte to write
//   strobe_n      in   1           raw pushbutton, active-low, bouncy
//   mem_we        out  1           RAM write enable, one-cycle pulse
//   mem_addr      out  ADDR_WIDTH  RAM write address
//   mem_wdata     out  8           RAM write data
//   hart_reset_n  out  1           active-low reset to hart; 0 while loading
//   next_addr     out  ADDR_WIDTH  address the next press writes (for HEX display)
//   wrapped       out  1           sticky: next_addr has wrapped in this load session
// BEHAVIOUR
//   Reset (async, all outputs registered):
//     mem_we=0, mem_addr=START_ADDR, mem_wdata=0, hart_reset_n=0, next_addr=START_ADDR,
//     wrapped=0, state=RUN, debounced key=released, debounce counter=0.
//     A pending write is dropped; mem_we falls immediately on reset_n=0.
//   Input conditioning:
//     - strobe_n and load_mode each pass through a 2-flop synchronizer.
//     - byte_in is sampled at the WRITE edge only.
//   Debounce:
//     - Counter resets whenever the synced key differs from its previous sample.
//     - Debounced level updates after DEBOUNCE_CYCLES consecutive equal samples.
//     - press event = debounced 1->0 for one cycle; release = debounced 0->1.
//   FSM (states RUN, LOAD_IDLE, WRITE, WAIT_RELEASE):
//     RUN:
//       - hart_reset_n=1.
//       - load_mode=1 -> LOAD_IDLE; next edge: hart_reset_n=0, next_addr=START_ADDR, wrapped=0.
//     LOAD_IDLE:
//       - press -> WRITE.
//       - load_mode=0 -> RUN.
//     WRITE (exactly 1 cycle):
//       - mem_we=1, mem_addr=next_addr, mem_wdata=byte_in.
//       - next_addr += 1 mod 2^ADDR_WIDTH; wrap to 0 sets wrapped.
//       - Then -> WAIT_RELEASE, or -> RUN if load_mode=0.
//     WAIT_RELEASE:
//       - release -> LOAD_IDLE.
//       - load_mode=0 -> RUN; load_mode takes priority over release.
//   Timing and edge cases:
//     - mem_we is 0 in every state except WRITE.
//     - hart_reset_n returns to 1 on the edge entering RUN; the hart restarts from its reset vector.
//     - Latency from the clean strobe_n fall to mem_we=1 is 2 + DEBOUNCE_CYCLES + 2 clocks.
//     - A held key gives one write; a bounce shorter than DEBOUNCE_CYCLES gives no event.
//     - A press while in RUN is ignored; no write and no address change.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1. Reset: drop reset_n mid-WRITE -> mem_we=0 same cycle, next_addr=0, hart_reset_n=0;
//      after release, hart_reset_n=1 at the first edge.
//   2. Load: load_mode=1, clean presses with bytes 0x13, 0x00, 0xA5 -> three single-cycle mem_we
//      pulses at addr 0/1/2 with those data; next_addr=3; hart_reset_n=0 throughout.
//   3. Bounce: strobe_n low pulses of 3 cycles -> no mem_we; then held low 20 cycles -> exactly one write.
//   4. Held key: press held 200 cycles, byte_in changed during hold -> one write carrying the byte
//      at the WRITE edge.
//   5. Wrap (ADDR_WIDTH=2): 5 presses -> addrs 0,1,2,3,0; wrapped=1 after the 4th write.
//   6. Exit/re-enter: load_mode=0 while key held -> RUN, hart_reset_n=1 next edge, no write;
//      load_mode=1 again -> next_addr=0, wrapped=0.

Source files
------------

// File: rtl/hart_program_loader.sv
// Board-side program loader: the operator sets a byte on the switches and presses a key,
// and the byte is written to the next RAM address. The hart is held in reset while loading
// and released on return to run mode.
module hart_program_loader #(
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned START_ADDR      = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_mode,
    input  logic [7:0]            byte_in,
    input  logic                  strobe_n,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  hart_reset_n,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  wrapped
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_ADDR);

    typedef enum logic [1:0] {StRun, StLoadIdle, StWrite, StWaitRelease} state_e;

    // Synchronizers; the key idles high (released), load_mode idles in run mode.
    logic strobe_meta_q, strobe_sync_q;
    logic load_meta_q, load_sync_q;

    // Debounce state
    logic            key_prev_q, key_prev_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            key_db_q, key_db_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // FSM state and registered outputs
    state_e                state_q, state_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  hart_reset_n_q, hart_reset_n_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic                  wrapped_q, wrapped_d;
    logic [ADDR_WIDTH-1:0] next_addr_inc;

    assign next_addr_inc = next_addr_q + ADDR_WIDTH'(1);

    // Debounce: the level is accepted only after DEBOUNCE_CYCLES equal consecutive samples.
    always_comb begin
        key_prev_d = strobe_sync_q;
        cnt_d      = cnt_q;
        key_db_d   = key_db_q;
        if (strobe_sync_q != key_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            key_db_d = strobe_sync_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        press_d   = key_db_q & ~key_db_d;
        release_d = ~key_db_q & key_db_d;
    end

    // Next-state and output logic; leaving load mode always wins over key events.
    always_comb begin
        state_d        = state_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        hart_reset_n_d = hart_reset_n_q;
        next_addr_d    = next_addr_q;
        wrapped_d      = wrapped_q;
        unique case (state_q)
            StRun: begin
                hart_reset_n_d = 1'b1;
                if (load_sync_q) begin
                    state_d        = StLoadIdle;
                    hart_reset_n_d = 1'b0;
                    next_addr_d    = StartAddr;
                    wrapped_d      = 1'b0;
                end
            end
            StLoadIdle: begin
                if (!load_sync_q) begin
                    state_d        = StRun;
                    hart_reset_n_d = 1'b1;
                end else if (press_q) begin
                    state_d     = StWrite;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = next_addr_q;
                    mem_wdata_d = byte_in;
                    next_addr_d = next_addr_inc;
                    if (next_addr_inc == '0) wrapped_d = 1'b1;
                end
            end
            StWrite: begin
                if (!load_sync_q) begin
                    state_d        = StRun;
                    hart_reset_n_d = 1'b1;
                end else begin
                    state_d = StWaitRelease;
                end
            end
            StWaitRelease: begin
                if (!load_sync_q) begin
                    state_d        = StRun;
                    hart_reset_n_d = 1'b1;
                end else if (release_q) begin
                    state_d = StLoadIdle;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // All state, including the FSM and its registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_meta_q  <= 1'b1;
            strobe_sync_q  <= 1'b1;
            load_meta_q    <= 1'b0;
            load_sync_q    <= 1'b0;
            key_prev_q     <= 1'b1;
            cnt_q          <= '0;
            key_db_q       <= 1'b1;
            press_q        <= 1'b0;
            release_q      <= 1'b0;
            state_q        <= StRun;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= StartAddr;
            mem_wdata_q    <= '0;
            hart_reset_n_q <= 1'b0;
            next_addr_q    <= StartAddr;
            wrapped_q      <= 1'b0;
        end else begin
            strobe_meta_q  <= strobe_n;
            strobe_sync_q  <= strobe_meta_q;
            load_meta_q    <= load_mode;
            load_sync_q    <= load_meta_q;
            key_prev_q     <= key_prev_d;
            cnt_q          <= cnt_d;
            key_db_q       <= key_db_d;
            press_q        <= press_d;
            release_q      <= release_d;
            state_q        <= state_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            hart_reset_n_q <= hart_reset_n_d;
            next_addr_q    <= next_addr_d;
            wrapped_q      <= wrapped_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign hart_reset_n = hart_reset_n_q;
    assign next_addr    = next_addr_q;
    assign wrapped      = wrapped_q;

endmodule
